// File: rtl/fx2_stream_writer.sv
// Buffered stream writer for the Cypress FX2 slave FIFO (EP6), with full-packet and short-packet commits.
// Optional build macro FX2_TEST_PATTERN_EN adds test_mode, which replaces the input stream with a counter.
module fx2_stream_writer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int PKT_LEN = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
`ifdef FX2_TEST_PATTERN_EN
  input  logic                     test_mode,
`endif
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     sync_n,
  input  logic                     flagd_n,
  output logic [DATA_W-1:0]        fd,
  output logic [1:0]               faddr,
  output logic                     slwr_n,
  output logic                     slrd_n,
  output logic                     sloe_n,
  output logic                     pktend_n,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              pkt_count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] PLEN = 16'(PKT_LEN);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, PKTEND} state_t;

  state_t            state, state_d, ret, ret_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [15:0]       wcnt;
  logic              push, pop;
  logic [DATA_W-1:0] push_data;

`ifdef FX2_TEST_PATTERN_EN
  logic [DATA_W-1:0] pat;

  assign push      = test_mode ? in_ready : (in_valid & in_ready);
  assign push_data = test_mode ? pat : in_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              pat <= '0;
    else if (test_mode && push) pat <= pat + DATA_W'(1);
  end
`else
  assign push      = in_valid & in_ready;
  assign push_data = in_data;
`endif

  assign in_ready   = (count != FULL);
  assign fill_level = count;
  assign faddr      = 2'b10;
  assign slrd_n     = 1'b1;
  assign sloe_n     = 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A full packet is committed one cycle after its last strobe, so slwr_n and
  // pktend_n are never low together.
  always_comb begin
    state_d = state;
    ret_d   = ret;
    pop     = 1'b0;
    case (state)
      IDLE: if (!sync_n) state_d = STREAM;
      STREAM: begin
        if (wcnt == PLEN) begin
          state_d = PKTEND;
          ret_d   = STREAM;
        end else begin
          pop = (count != '0) && flagd_n;
          if (sync_n) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wcnt == PLEN) begin
          state_d = PKTEND;
          ret_d   = DRAIN;
        end else if (!sync_n) begin
          state_d = STREAM;
          pop     = (count != '0) && flagd_n;
        end else if (count == '0) begin
          if (wcnt != '0) begin
            state_d = PKTEND;
            ret_d   = IDLE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pop = flagd_n;
        end
      end
      PKTEND:  state_d = ret;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ret       <= IDLE;
      wcnt      <= '0;
      pkt_count <= '0;
      fd        <= '0;
      slwr_n    <= 1'b1;
      pktend_n  <= 1'b1;
    end else begin
      state    <= state_d;
      ret      <= ret_d;
      slwr_n   <= ~pop;
      pktend_n <= (state_d != PKTEND);
      if (pop) fd <= mem[rd_ptr];
      if (state == PKTEND) begin
        wcnt      <= '0;
        pkt_count <= pkt_count + 16'd1;
      end else if (pop) begin
        wcnt <= wcnt + 16'd1;
      end
    end
  end

endmodule
